// File: rtl/otp_pkg.sv
// Shared definitions for the one-time-pad cipher engine: the FSM state enum,
// the request mode encoding and the default Galois tap masks for each
// generator width.
package otp_pkg;

  typedef enum logic {
    ZERO = 1'b0,
    RUN  = 1'b1
  } otp_state_e;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  // Right-shifting Galois masks for maximal-length polynomials. Widths not
  // listed fall back to x^w + 1 so that feedback is never all-zero.
  function automatic logic [63:0] default_taps(input int unsigned width);
    logic [63:0] taps;
    case (width)
      8:       taps = 64'h0000_0000_0000_00B8;
      16:      taps = 64'h0000_0000_0000_B400;
      24:      taps = 64'h0000_0000_00E1_0000;
      32:      taps = 64'h0000_0000_8020_0003;
      64:      taps = 64'hD800_0000_0000_0000;
      default: taps = (64'd1 << (width - 1)) | 64'd1;
    endcase
    return taps;
  endfunction

endpackage

// File: rtl/otp_lfsr.sv
// Galois LFSR pad generator. Advances one step per cycle when step is high.
// Ports:
//   clk, rst_n   clock and synchronous active-low reset (loads SEED)
//   step         advance the generator by one state
//   pad          low OUT_W bits of the current state
module otp_lfsr
  import otp_pkg::*;
#(
  parameter int unsigned            WIDTH = 16,
  parameter int unsigned            OUT_W = 8,
  parameter logic [WIDTH-1:0]       SEED  = WIDTH'(16'hACE1),
  parameter logic [WIDTH-1:0]       TAPS  = WIDTH'(default_taps(WIDTH))
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step,
  output logic [OUT_W-1:0] pad
);

  logic [WIDTH-1:0] state_q;

  // Shift right; the bit falling out of the LSB folds back through the taps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= SEED;
    end else if (step) begin
      state_q <= (state_q >> 1) ^ ({WIDTH{state_q[0]}} & TAPS);
    end
  end

  assign pad = state_q[OUT_W-1:0];

endmodule

// File: rtl/otp_cipher_engine.sv
// One-time-pad cipher engine. Encrypts draw a fresh pad from the LFSR, store it
// in a small pad slot array and return the slot index; decrypts XOR with a
// stored pad selected by index. After reset the pad store is zeroed one slot
// per cycle before requests are accepted.
// Optional feature: define OTP_ONE_SHOT_EN to invalidate a pad after its first
// successful decrypt.
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   ena                            block enable; low freezes all state
//   in_valid/in_ready              request handshake
//   in_data, in_mode, in_idx       request payload (mode 0 enc, 1 dec)
//   out_valid/out_ready            response handshake
//   out_data, out_idx, out_err     response payload
//   pad_count                      number of valid pad slots
module otp_cipher_engine
  import otp_pkg::*;
#(
  parameter int unsigned       DATA_W    = 8,
  parameter int unsigned       PAD_DEPTH = 8,
  parameter int unsigned       LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_W'(16'hACE1),
  localparam int unsigned      IDX_W     = $clog2(PAD_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_mode,
  input  logic [IDX_W-1:0]  in_idx,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_err,
  output logic [IDX_W:0]    pad_count
);

  localparam int unsigned CNT_W = IDX_W + 1;

  otp_state_e        state_q, state_d;
  logic [IDX_W-1:0]  clr_ptr_q;
  logic [IDX_W-1:0]  wr_ptr_q;
  logic [PAD_DEPTH-1:0] valid_q;
  logic [DATA_W-1:0] mem_q [PAD_DEPTH];
  logic [DATA_W-1:0] pad;
  logic              accept, enc, dec, dec_hit, zeroing;

  assign in_ready = ena && (state_q == RUN) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign enc      = accept && (in_mode == MODE_ENC);
  assign dec      = accept && (in_mode == MODE_DEC);
  assign dec_hit  = dec && valid_q[in_idx];
  assign zeroing  = ena && (state_q == ZERO);

  otp_lfsr #(
    .WIDTH (LFSR_W),
    .OUT_W (DATA_W),
    .SEED  (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (enc),
    .pad   (pad)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ZERO;
    else        state_q <= state_d;
  end

  // Next state: leave ZERO once the last slot has been cleared
  always_comb begin
    state_d = state_q;
    case (state_q)
      ZERO:    if (ena && (clr_ptr_q == IDX_W'(PAD_DEPTH - 1))) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = ZERO;
    endcase
  end

  // Pad storage; no reset, it is scrubbed during ZERO instead
  always_ff @(posedge clk) begin
    if (zeroing) begin
      mem_q[clr_ptr_q] <= '0;
    end else if (enc) begin
      mem_q[wr_ptr_q] <= pad;
    end
  end

  // Control, slot bookkeeping and response registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clr_ptr_q <= '0;
      wr_ptr_q  <= '0;
      valid_q   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_err   <= 1'b0;
      pad_count <= '0;
    end else begin
      if (zeroing) begin
        clr_ptr_q          <= clr_ptr_q + IDX_W'(1);
        valid_q[clr_ptr_q] <= 1'b0;
      end

      if (accept)                out_valid <= 1'b1;
      else if (ena && out_ready) out_valid <= 1'b0;

      if (enc) begin
        out_data          <= in_data ^ pad;
        out_idx           <= wr_ptr_q;
        out_err           <= 1'b0;
        valid_q[wr_ptr_q] <= 1'b1;
        // Overwriting a live slot leaves the count unchanged (saturation)
        if (!valid_q[wr_ptr_q]) pad_count <= pad_count + CNT_W'(1);
        wr_ptr_q          <= wr_ptr_q + IDX_W'(1);
      end else if (dec) begin
        out_idx <= in_idx;
        if (dec_hit) begin
          out_data <= mem_q[in_idx] ^ in_data;
          out_err  <= 1'b0;
`ifdef OTP_ONE_SHOT_EN
          valid_q[in_idx] <= 1'b0;
          pad_count       <= pad_count - CNT_W'(1);
`endif
        end else begin
          out_data <= '0;
          out_err  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_otp_cipher_engine.sv
// Bench for otp_cipher_engine: directed stimulus, a transaction-level model
// checked every cycle, and literal expectations pinning the pad sequence.
module tb_otp_cipher_engine;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned PAD_DEPTH = 8;
  localparam int unsigned IDX_W     = 3;

  logic              clk;
  logic              rst_n;
  logic              ena;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_mode;
  logic [IDX_W-1:0]  in_idx;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [IDX_W-1:0]  out_idx;
  logic              out_err;
  logic [IDX_W:0]    pad_count;

  otp_cipher_engine #(
    .DATA_W    (DATA_W),
    .PAD_DEPTH (PAD_DEPTH),
    .LFSR_W    (16),
    .LFSR_SEED (16'hACE1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .in_idx    (in_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_err   (out_err),
    .pad_count (pad_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  bit          m_live = 1'b0;
  int          m_zero_left;
  logic [15:0] m_gen;
  logic [7:0]  m_pad [PAD_DEPTH];
  bit          m_vld [PAD_DEPTH];
  int          m_wr;
  bit          m_ov;
  logic [7:0]  m_od;
  logic [2:0]  m_oi;
  bit          m_oe;

  // Generator as multiplication by x^-1 over GF(2)[x]/(x^16+x^14+x^13+x^11+1)
  function automatic logic [15:0] gen_next(input logic [15:0] x);
    return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < PAD_DEPTH; i++) if (m_vld[i]) c++;
    return c;
  endfunction

  always @(negedge clk) begin
    bit rdy;
    rdy = ena && (m_zero_left == 0) && (!m_ov || out_ready);
    if (m_live) begin
      check("out_valid", 32'(out_valid), 32'(m_ov));
      if (m_ov) begin
        check("out_data", 32'(out_data), 32'(m_od));
        check("out_idx",  32'(out_idx),  32'(m_oi));
        check("out_err",  32'(out_err),  32'(m_oe));
      end
      check("in_ready",  32'(in_ready),  32'(rdy));
      check("pad_count", 32'(pad_count), 32'(m_count()));
    end
    if (!rst_n) begin
      m_live      = 1'b1;
      m_zero_left = PAD_DEPTH;
      m_gen       = 16'hACE1;
      for (int i = 0; i < PAD_DEPTH; i++) m_vld[i] = 1'b0;
      m_wr = 0; m_ov = 1'b0; m_od = '0; m_oi = '0; m_oe = 1'b0;
    end else if (m_live) begin
      if (ena && m_zero_left > 0) m_zero_left--;
      if (in_valid && rdy) begin
        m_ov = 1'b1;
        if (in_mode == 1'b0) begin
          m_pad[m_wr] = m_gen[7:0];
          m_vld[m_wr] = 1'b1;
          m_od = in_data ^ m_gen[7:0];
          m_oi = 3'(m_wr);
          m_oe = 1'b0;
          m_wr = (m_wr + 1) % PAD_DEPTH;
          m_gen = gen_next(m_gen);
        end else begin
          m_oi = in_idx;
          if (m_vld[in_idx]) begin
            m_od = m_pad[in_idx] ^ in_data;
            m_oe = 1'b0;
`ifdef OTP_ONE_SHOT_EN
            m_vld[in_idx] = 1'b0;
`endif
          end else begin
            m_od = '0;
            m_oe = 1'b1;
          end
        end
      end else if (ena && out_ready) begin
        m_ov = 1'b0;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  // Inputs change 1 time unit after a rising edge; returns at accept edge + 1.
  task automatic do_txn(input logic mode, input logic [2:0] idx, input logic [7:0] data,
                        output int waits);
    bit done = 1'b0;
    in_valid = 1'b1; in_mode = mode; in_idx = idx; in_data = data;
    waits = 0;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        done = 1'b1;
      end else begin
        waits++;
        @(posedge clk); #1;
      end
    end
    if (!done) in_valid = 1'b0;
    check("txn_accept_timeout", 32'(done), 32'd1);
  endtask

  logic [7:0] pads [9];
  int w;

  initial begin
    pads = '{8'hE1, 8'h70, 8'h38, 8'h9C, 8'h4E, 8'h27, 8'h13, 8'h89, 8'hC4};
    rst_n = 1'b0; ena = 1'b1; in_valid = 1'b0; in_mode = 1'b0;
    in_data = '0; in_idx = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_out_idx",   32'(out_idx),   32'd0);
    check("rst_out_err",   32'(out_err),   32'd0);
    check("rst_pad_count", 32'(pad_count), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd0);
    rst_n = 1'b1;

    // First encrypt waits out the zeroing phase
    do_txn(1'b0, 3'd0, 8'h00, w);
    check("zero_cycles",     32'(w),         32'd8);
    check("enc0_data",       32'(out_data),  32'hE1);
    check("enc0_idx",        32'(out_idx),   32'd0);
    check("enc0_err",        32'(out_err),   32'd0);
    check("enc0_pad_count",  32'(pad_count), 32'd1);

    do_txn(1'b1, 3'd0, 8'hE1, w);
    check("dec0_data", 32'(out_data), 32'h00);
    check("dec0_err",  32'(out_err),  32'd0);
    do_txn(1'b1, 3'd0, 8'hE1, w);
    check("dec0_again_data", 32'(out_data), 32'h00);
`ifdef OTP_ONE_SHOT_EN
    check("dec0_again_err", 32'(out_err), 32'd1);
`else
    check("dec0_again_err", 32'(out_err), 32'd0);
`endif

    // Fresh reset: nine encrypts wrap the write pointer, count saturates
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      do_txn(1'b0, 3'd0, 8'(i * 17), w);
      check("wrap_idx",   32'(out_idx),   32'(i % 8));
      check("wrap_data",  32'(out_data),  32'(8'(i * 17) ^ pads[i]));
      check("wrap_count", 32'(pad_count), 32'((i < 8) ? i + 1 : 8));
    end

    do_txn(1'b1, 3'd1, 8'h61, w);
    check("dec1_data", 32'(out_data), 32'h11);
    check("dec1_err",  32'(out_err),  32'd0);

    // Backpressure: result holds, no request accepted, generator frozen
    out_ready = 1'b0;
    in_valid = 1'b1; in_mode = 1'b0; in_data = 8'h00;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_valid",    32'(out_valid), 32'd1);
      check("stall_data",     32'(out_data),  32'h11);
      check("stall_idx",      32'(out_idx),   32'd1);
      check("stall_in_ready", 32'(in_ready),  32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    do_txn(1'b0, 3'd0, 8'h00, w);
    check("post_stall_data",  32'(out_data),  32'h62);
    check("post_stall_idx",   32'(out_idx),   32'd1);
    check("post_stall_count", 32'(pad_count), 32'd8);

    // Back-to-back encrypts, one per cycle
    in_valid = 1'b1; in_mode = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_data = 8'(8'hA0 + k);
      @(negedge clk);
      check("stream_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;

    // Disabled block ignores requests and holds its output
    ena = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("ena_low_ready", 32'(in_ready),  32'd0);
      check("ena_low_valid", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
    end
    ena = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;

    // Reset with a pending response
    out_ready = 1'b0;
    do_txn(1'b0, 3'd0, 8'h5A, w);
    check("pend_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_count", 32'(pad_count), 32'd0);
    rst_n = 1'b1; out_ready = 1'b1;
    do_txn(1'b1, 3'd2, 8'h33, w);
    check("midrst_zero_cycles", 32'(w),        32'd8);
    check("midrst_dec_err",     32'(out_err),  32'd1);
    check("midrst_dec_data",    32'(out_data), 32'd0);
    check("midrst_dec_idx",     32'(out_idx),  32'd2);

    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
